mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one downstream memory port between an instruction
// fetch bus (ibus) and a data bus (dbus). The winning request is copied into
// a request buffer, and the buffer drives mem_*. Responses go back only to
// the granted side. After each transaction the arbiter spends one idle cycle
// before it grants again.
//
// Packed port layouts, MSB first:
//   ibus_req  [64:0]  = {valid, addr[63:0]}
//   ibus_resp [33:0]  = {addr_ok, data_ok, data[31:0]}
//   dbus_req  [139:0] = {valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]}
//   dbus_resp [65:0]  = {addr_ok, data_ok, data[63:0]}
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate ties between
// the two requesters. Without it, dbus always wins a tie and no pointer flop
// is built.
module mem_bus_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic [64:0]  ibus_req,
  output logic [33:0]  ibus_resp,
  input  logic [139:0] dbus_req,
  output logic [65:0]  dbus_resp,
  output logic         mem_valid,
  output logic [63:0]  mem_addr,
  output logic         mem_write,
  output logic [2:0]   mem_size,
  output logic [7:0]   mem_strobe,
  output logic [63:0]  mem_wdata,
  input  logic         mem_addr_ok,
  input  logic         mem_data_ok,
  input  logic [63:0]  mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t       r_state;
  logic         r_memValid;
  logic [63:0]  r_memAddr;
  logic         r_memWrite;
  logic [2:0]   r_memSize;
  logic [7:0]   r_memStrobe;
  logic [63:0]  r_memWdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic         r_rrPtr;
`endif

  logic         w_ibusValid;
  logic [63:0]  w_ibusAddr;
  logic         w_dbusValid;
  logic [63:0]  w_dbusAddr;
  logic [2:0]   w_dbusSize;
  logic [7:0]   w_dbusStrobe;
  logic [63:0]  w_dbusData;
  logic         w_pickDbus;
  logic         w_pickIbus;
  logic [31:0]  w_ibusData;

  assign w_ibusValid  = ibus_req[64];
  assign w_ibusAddr   = ibus_req[63:0];
  assign w_dbusValid  = dbus_req[139];
  assign w_dbusAddr   = dbus_req[138:75];
  assign w_dbusSize   = dbus_req[74:72];
  assign w_dbusStrobe = dbus_req[71:64];
  assign w_dbusData   = dbus_req[63:0];

  // Choose the winner while idle. A pointer value of 0 favours dbus.
`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign w_pickDbus = w_dbusValid && (!w_ibusValid || !r_rrPtr);
`else
  assign w_pickDbus = w_dbusValid;
`endif
  assign w_pickIbus = w_ibusValid && !w_pickDbus;

  // The fetch side gets the 32-bit half of the 64-bit beat that addr[2] selects.
  assign w_ibusData = r_memAddr[2] ? mem_rdata[63:32] : mem_rdata[31:0];

  assign mem_valid  = r_memValid;
  assign mem_addr   = r_memAddr;
  assign mem_write  = r_memWrite;
  assign mem_size   = r_memSize;
  assign mem_strobe = r_memStrobe;
  assign mem_wdata  = r_memWdata;

  // Arbitration FSM. It also owns the request buffer and the registered mem_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_memValid  <= 1'b0;
      r_memAddr   <= 64'd0;
      r_memWrite  <= 1'b0;
      r_memSize   <= 3'd0;
      r_memStrobe <= 8'd0;
      r_memWdata  <= 64'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_rrPtr     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pickDbus) begin
            r_state     <= GRANT_D;
            r_memValid  <= 1'b1;
            r_memAddr   <= w_dbusAddr;
            r_memWrite  <= |w_dbusStrobe;
            r_memSize   <= w_dbusSize;
            r_memStrobe <= w_dbusStrobe;
            r_memWdata  <= w_dbusData;
          end else if (w_pickIbus) begin
            r_state     <= GRANT_I;
            r_memValid  <= 1'b1;
            r_memAddr   <= w_ibusAddr;
            r_memWrite  <= 1'b0;
            r_memSize   <= 3'b010;
            r_memStrobe <= 8'd0;
            r_memWdata  <= 64'd0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (mem_addr_ok) begin
            r_memValid <= 1'b0;
          end
          if (mem_data_ok) begin
            r_state    <= IDLE;
            r_memValid <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_rrPtr    <= (r_state == GRANT_D);
`endif
          end
        end
        default: begin
          r_state    <= IDLE;
          r_memValid <= 1'b0;
        end
      endcase
    end
  end

  // Pass the downstream handshakes through to the granted side only.
  always_comb begin
    ibus_resp = 34'd0;
    dbus_resp = 66'd0;
    case (r_state)
      GRANT_I: ibus_resp = {mem_addr_ok, mem_data_ok, w_ibusData};
      GRANT_D: dbus_resp = {mem_addr_ok, mem_data_ok, mem_rdata};
      default: begin
        ibus_resp = 34'd0;
        dbus_resp = 66'd0;
      end
    endcase
  end

endmodule
